// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and read-request type for the
// multi-port register file (regfile_mp, regfile_scoreboard).
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;
  // Widest address the register file supports (DEPTH up to 64).
  localparam int ADR_MAX   = 6;

  function automatic int adr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic [ADR_MAX-1:0] adr;
    logic               busy;
  } rd_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: writebacks clear, issues set (issue wins on
// the same register), and BusyCnt tracks the population of set bits.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = adr_width(DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_adr,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_adr,
  output logic [DEPTH-1:0]  busy_o,
  output logic [AW:0]       busy_cnt_o
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) busy_d[wr_adr[p*AW +: AW]] = 1'b0;
    end
    // Issue is applied last so a new producer supersedes a retiring one.
    if (issue_en && !(ZR && issue_adr == '0)) busy_d[issue_adr] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (busy_d[r] && !busy_q[r]) cnt_d = cnt_d + (AW+1)'(1);
      if (!busy_d[r] && busy_q[r]) cnt_d = cnt_d - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with async clear, optional hardwired x0 and busy
// scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = adr_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   RdAdr,
  output logic [NRD*XLEN-1:0] Read,
  output logic [NRD-1:0]      RdBusy,
  input  logic [NWR-1:0]      WrEn,
  input  logic [NWR*AW-1:0]   WrAdr,
  input  logic [NWR*XLEN-1:0] WrData,
  input  logic                IssueEn,
  input  logic [AW-1:0]       IssueAdr,
  output logic [AW:0]         BusyCnt
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [XLEN-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0] busy;
  rd_req_t          rd_req [NRD];

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (WrEn),
    .wr_adr     (WrAdr),
    .issue_en   (IssueEn),
    .issue_adr  (IssueAdr),
    .busy_o     (busy),
    .busy_cnt_o (BusyCnt)
  );

  // Ascending port order makes the highest-index port win on address clashes.
  always_comb begin
    logic [AW-1:0] wa;
    wa    = '0;
    mem_d = mem_q;
    for (int p = 0; p < NWR; p++) begin
      wa = WrAdr[p*AW +: AW];
      if (WrEn[p] && !(ZR && wa == '0)) mem_d[wa] = WrData[p*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdata;
    logic            fwd;
    ra     = '0;
    rdata  = '0;
    fwd    = 1'b0;
    Read   = '0;
    RdBusy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra             = RdAdr[i*AW +: AW];
      rd_req[i].adr  = ADR_MAX'(ra);
      rd_req[i].busy = busy[ra];
      rdata          = mem_q[ra];
      fwd            = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (WrEn[p] && rd_req[i].adr == ADR_MAX'(WrAdr[p*AW +: AW]) &&
            !(ZR && rd_req[i].adr == '0)) begin
          rdata = WrData[p*XLEN +: XLEN];
          fwd   = 1'b1;
        end
      end
      // A same-cycle issue to this register keeps it visibly pending.
      if (fwd && !(IssueEn && IssueAdr == ra)) rd_req[i].busy = 1'b0;
`endif
      if (ZR && rd_req[i].adr == '0) rdata = '0;
      Read[i*XLEN +: XLEN] = rdata;
      RdBusy[i]            = rd_req[i].busy & ~fwd | rd_req[i].busy & fwd;
    end
  end

endmodule
